memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- MEM stage of the 5-stage pipeline, between the EX/MEM register and the write-back mux.
- Issues load/store requests to data memory over a valid/ready handshake, stalling the pipeline for wait states.
- Aligns and sign/zero-extends load data, generates store byte enables, and registers the MEM/WB results.
- Its outputs aluData, memoryData and writeBackMemoryOrAlu feed the write-back mux directly.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width (only 32 supported).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- exValid  in  1  EX/MEM entry holds a real instruction.
- aluResult  in  32  ALU result; effective address for loads and stores.
- storeData  in  32  rs2 value for stores.
- funct3  in  3  access size/sign (RV32I load/store encodings).
- memRead  in  1  load.
- memWrite  in  1  store.
- regWriteIn  in  1  instruction writes rd.
- rdIn  in  5  destination register.
- wbSelIn  in  1  1 = write back memory data, 0 = ALU data.
- dmemReq  out  1  memory request valid.
- dmemWe  out  1  1 = write.
- dmemAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmemWdata  out  32  lane-replicated store data.
- dmemByteEn  out  4  byte lane enables.
- dmemReady  in  1  memory accepts/completes request this cycle.
- dmemRdata  in  32  read word, valid when dmemReady && !dmemWe.
- memStall  out  1  freeze IF..EX/MEM this cycle.
- wbValid  out  1  MEM/WB entry valid.
- aluData  out  32  registered ALU result.
- memoryData  out  32  registered, extended load data.
- writeBackMemoryOrAlu  out  1  registered wbSelIn.
- regWrite  out  1  registered write enable (forced 0 on bubble/fault).
- rd  out  5  registered destination.
- misalignedFault  out  1  registered, 1-cycle pulse with the faulting entry.

Behaviour:
- Reset (rst_n low, any time, including mid-WAIT): state IDLE, all outputs 0, dmemReq drops immediately; any in-flight request is abandoned and the memory is reset with the core.
- memOp = exValid && (memRead || memWrite) && aligned && legal funct3.
- IDLE: dmemReq = memOp, driven combinationally from the inputs.
  - If dmemReady is seen the same cycle, the access completes with zero wait states: 1-cycle latency to the WB registers.
  - Otherwise latch addr, wdata, byteEn, funct3, rd, controls and go to WAIT.
- WAIT: dmemReq held at 1 with latched fields (stable until ready). On dmemReady: complete from latched fields, go to IDLE.
- memStall = (IDLE && memOp && !dmemReady) || (WAIT && !dmemReady). Upstream holds its inputs while memStall is 1.
- WB register load, every cycle:
  - If memStall: wbValid=0 and regWrite=0 (bubble); data registers hold.
  - Else load from the current or completing instruction; wbValid=exValid.
  - Non-memory instructions pass in 1 cycle, with no dmemReq.
- Store lanes:
  - SB: byteEn = 4'b0001 << addr[1:0]; data = {4{sd[7:0]}}.
  - SH: byteEn = 4'b0011 << addr[1:0]; data = {2{sd[15:0]}}.
  - SW: byteEn = 4'b1111; data = sd.
- Loads: select byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - For stores, memoryData = 0.
- Faults: halfword with addr[0]=1, word with addr[1:0]!=0, or illegal funct3 (loads 011/110/111; stores 011..111).
  - No memory request and no stall.
  - WB entry valid, with regWrite=0 and misalignedFault=1 for one cycle.
- Back-to-back memory ops: the next op may issue in the cycle after completion (IDLE), never in the completion cycle itself.
- Memory must not assert dmemReady without dmemReq; if it does, the stage ignores it.

Decomposition:
- Package memory_stage_pkg:
  - funct3 constants (F3_B/H/W/BU/HU).
  - State enum {IDLE, WAIT}.
  - Typedef mem_req_t {addr, wdata, byteEn, we, funct3, rd, regWrite, wbSel}.
- Sub-module load_store_align (combinational): storeData/funct3/addr[1:0] -> wdata/byteEn/fault; rdata/funct3/addr[1:0] -> extended load data.

Test Plan:
- Reset mid-WAIT (dmemReady held 0, rst_n pulsed low) -> dmemReq, memStall, wbValid and all outputs 0 immediately; IDLE afterwards.
- LB at 0x1003, rdata=0x80FF_0000, ready the same cycle -> memStall=0, next cycle memoryData=0xFFFF_FF80, wbValid=1, writeBackMemoryOrAlu=1.
- SH at 0x2002, storeData=0x1234_ABCD, ready after 3 cycles -> dmemByteEn=1100, dmemWdata=0xABCD_ABCD held stable; memStall=1 for exactly 3 cycles; wbValid=0 during them, then 1 with regWrite=0.
- LW at 0x3001 -> dmemReq stays 0, no stall; next cycle misalignedFault=1, regWrite=0, wbValid=1.
- ADD (no mem op), aluResult=0x55, regWriteIn=1, rdIn=7 -> next cycle aluData=0x55, rd=7, regWrite=1, no dmemReq.
- LHU at 0x4002 then SW at 0x4004 back-to-back, both 1-wait -> two stalls; byteEn 1111 on the second; memoryData=rdata[31:16] zero-extended for the first.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// memory_stage_pkg: shared funct3 encodings, FSM state and latched request type for the MEM stage
package memory_stage_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic {IDLE, WAIT} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteEn;
        logic        we;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        regWrite;
        logic        wbSel;
    } mem_req_t;
endpackage

// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if: data-memory valid/ready bus
// master (stage): drives dmemReq/dmemWe/dmemAddr/dmemWdata/dmemByteEn, samples dmemReady/dmemRdata
// slave (memory): drives dmemReady/dmemRdata
interface memory_access_stage_if;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemByteEn;
    logic        dmemReady;
    logic [31:0] dmemRdata;
    modport master(output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemByteEn, input dmemReady, dmemRdata);
    modport slave(input dmemReq, dmemWe, dmemAddr, dmemWdata, dmemByteEn, output dmemReady, dmemRdata);
endinterface

// File: rtl/memory_access_stage_align.sv
// load_store_align: store lane replication/byte enables, access legality, and load extraction/extension
// store side: storeData, funct3, addrLo, isStore -> wdata, byteEn, fault
// load side:  rdata, ldFunct3, ldAddrLo -> loadData
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] storeData,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic        isStore,
    output logic [31:0] wdata,
    output logic [3:0]  byteEn,
    output logic        fault,
    input  logic [31:0] rdata,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldAddrLo,
    output logic [31:0] loadData
);
    logic       legal;
    logic       misaligned;
    logic [7:0] b;
    logic [15:0] h;
    always_comb begin
        legal = isStore ? (funct3 inside {F3_B, F3_H, F3_W}) : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = (funct3[1:0] == 2'b01 && addrLo[0]) || (funct3[1:0] == 2'b10 && addrLo != 2'b00);
        fault = !legal || misaligned;
        byteEn = funct3[1:0] == 2'b00 ? 4'b0001 << addrLo : funct3[1:0] == 2'b01 ? 4'b0011 << addrLo : 4'b1111;
        wdata = funct3[1:0] == 2'b00 ? {4{storeData[7:0]}} : funct3[1:0] == 2'b01 ? {2{storeData[15:0]}} : storeData;
        b = rdata[{ldAddrLo, 3'b000} +: 8];
        h = ldAddrLo[1] ? rdata[31:16] : rdata[15:0];
        loadData = ldFunct3 == F3_B  ? {{24{b[7]}}, b} :
                   ldFunct3 == F3_BU ? {24'b0, b} :
                   ldFunct3 == F3_H  ? {{16{h[15]}}, h} :
                   ldFunct3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage issuing data-memory accesses and registering MEM/WB results
// in:  clk, rst_n, exValid, aluResult, storeData, funct3, memRead, memWrite, regWriteIn, rdIn, wbSelIn
// bus: dmem (master modport of memory_access_stage_if)
// out: memStall, wbValid, aluData, memoryData, writeBackMemoryOrAlu, regWrite, rd, misalignedFault
module memory_access_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exValid,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    input  logic [2:0]  funct3,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWriteIn,
    input  logic [4:0]  rdIn,
    input  logic        wbSelIn,
    memory_access_stage_if.master dmem,
    output logic        memStall,
    output logic        wbValid,
    output logic [31:0] aluData,
    output logic [31:0] memoryData,
    output logic        writeBackMemoryOrAlu,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic        misalignedFault
);
    if (DATA_WIDTH != 32 || ADDR_WIDTH != 32) begin : g_width_check
        $error("memory_access_stage supports only 32-bit data and address");
    end
    state_t      state;
    mem_req_t    lat;
    mem_req_t    fresh;
    mem_req_t    cur;
    logic        memAcc;
    logic        alignFault;
    logic        fault;
    logic        memOp;
    logic        complete;
    logic [31:0] wdata;
    logic [31:0] loadData;
    logic [3:0]  byteEn;
    // load extraction follows the request actually on the bus (latched while waiting)
    load_store_align u_align (
        .storeData(storeData),
        .funct3(funct3),
        .addrLo(aluResult[1:0]),
        .isStore(memWrite),
        .wdata(wdata),
        .byteEn(byteEn),
        .fault(alignFault),
        .rdata(dmem.dmemRdata),
        .ldFunct3(cur.funct3),
        .ldAddrLo(cur.addr[1:0]),
        .loadData(loadData)
    );
    always_comb begin
        memAcc = exValid && (memRead || memWrite);
        fault = memAcc && alignFault;
        memOp = memAcc && !alignFault;
        fresh = '{addr: aluResult, wdata: wdata, byteEn: byteEn, we: memWrite, funct3: funct3,
                  rd: rdIn, regWrite: regWriteIn, wbSel: wbSelIn};
        cur = state == WAIT ? lat : fresh;
        // gated by rst_n so the request drops the instant reset asserts
        dmem.dmemReq = rst_n && (state == WAIT || memOp);
        dmem.dmemWe = dmem.dmemReq && cur.we;
        dmem.dmemAddr = dmem.dmemReq ? {cur.addr[31:2], 2'b00} : '0;
        dmem.dmemWdata = dmem.dmemReq && cur.we ? cur.wdata : '0;
        dmem.dmemByteEn = dmem.dmemReq ? cur.byteEn : '0;
        // a ready without a request is ignored
        complete = dmem.dmemReq && dmem.dmemReady;
        memStall = dmem.dmemReq && !dmem.dmemReady;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lat <= '0;
            wbValid <= 1'b0;
            aluData <= '0;
            memoryData <= '0;
            writeBackMemoryOrAlu <= 1'b0;
            regWrite <= 1'b0;
            rd <= '0;
            misalignedFault <= 1'b0;
        end else begin
            if (state == IDLE && memOp && !dmem.dmemReady) begin
                state <= WAIT;
                lat <= fresh;
            end else if (complete) begin
                state <= IDLE;
            end
            if (memStall) begin
                wbValid <= 1'b0;
                regWrite <= 1'b0;
                misalignedFault <= 1'b0;
            end else begin
                wbValid <= state == WAIT || exValid;
                aluData <= cur.addr;
                memoryData <= complete && !cur.we ? loadData : '0;
                writeBackMemoryOrAlu <= cur.wbSel;
                regWrite <= cur.regWrite && (state == WAIT || (exValid && !fault));
                rd <= cur.rd;
                misalignedFault <= state == IDLE && fault;
            end
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed vectors with a scoreboard-checked MEM/WB stream
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exValid = 1'b0;
    logic [31:0] aluResult = '0;
    logic [31:0] storeData = '0;
    logic [2:0]  funct3 = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        regWriteIn = 1'b0;
    logic [4:0]  rdIn = '0;
    logic        wbSelIn = 1'b0;
    logic        memStall;
    logic        wbValid;
    logic [31:0] aluData;
    logic [31:0] memoryData;
    logic        writeBackMemoryOrAlu;
    logic        regWrite;
    logic [4:0]  rd;
    logic        misalignedFault;
    memory_access_stage_if dmem();
    memory_access_stage dut (
        .clk(clk), .rst_n(rst_n), .exValid(exValid), .aluResult(aluResult), .storeData(storeData),
        .funct3(funct3), .memRead(memRead), .memWrite(memWrite), .regWriteIn(regWriteIn), .rdIn(rdIn),
        .wbSelIn(wbSelIn), .dmem(dmem), .memStall(memStall), .wbValid(wbValid), .aluData(aluData),
        .memoryData(memoryData), .writeBackMemoryOrAlu(writeBackMemoryOrAlu), .regWrite(regWrite),
        .rd(rd), .misalignedFault(misalignedFault)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic        wbs;
        logic        rw;
        logic        flt;
        logic [4:0]  rd;
    } exp_t;
    exp_t q[$];
    exp_t mx;
    int   passed = 0;
    int   total = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask
    always @(negedge clk) begin
        if (rst_n && wbValid) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL wb_unexpected: got wbValid=1 rd=%0d expected no entry", rd);
            end else begin
                mx = q.pop_front();
                chk("aluData", aluData, mx.alu);
                chk("memoryData", memoryData, mx.mem);
                chk("wbSel", {31'b0, writeBackMemoryOrAlu}, {31'b0, mx.wbs});
                chk("regWrite", {31'b0, regWrite}, {31'b0, mx.rw});
                chk("fault", {31'b0, misalignedFault}, {31'b0, mx.flt});
                chk("rd", {27'b0, rd}, {27'b0, mx.rd});
            end
        end
    end
    task automatic op(input logic ev, mr, mw, rwi, wbs, input logic [2:0] f3, input logic [31:0] alu, sd,
                      input logic [4:0] r, input int waits, input logic [31:0] rdat, emem,
                      input logic erw, eflt, ereq, spur, input logic [3:0] ebe, input logic [31:0] ewd);
        exValid = ev; memRead = mr; memWrite = mw; regWriteIn = rwi; wbSelIn = wbs;
        funct3 = f3; aluResult = alu; storeData = sd; rdIn = r;
        if (ev) q.push_back('{alu, emem, wbs, erw, eflt, r});
        for (int k = 0; k <= waits; k++) begin
            dmem.dmemReady = (k == waits) && (ereq || spur);
            dmem.dmemRdata = rdat;
            @(negedge clk);
            chk("dmemReq", {31'b0, dmem.dmemReq}, {31'b0, ereq});
            chk("memStall", {31'b0, memStall}, {31'b0, ereq && k < waits});
            if (k > 0) chk("wbValid_stall", {31'b0, wbValid}, 32'd0);
            if (ereq) begin
                chk("dmemAddr", dmem.dmemAddr, {alu[31:2], 2'b00});
                chk("dmemWe", {31'b0, dmem.dmemWe}, {31'b0, mw});
                if (mw) begin
                    chk("dmemByteEn", {28'b0, dmem.dmemByteEn}, {28'b0, ebe});
                    chk("dmemWdata", dmem.dmemWdata, ewd);
                end
            end
            @(posedge clk);
            #1;
        end
        dmem.dmemReady = 1'b0;
    endtask
    initial begin
        dmem.dmemReady = 1'b0;
        dmem.dmemRdata = '0;
        #1;
        chk("rst_dmemReq", {31'b0, dmem.dmemReq}, 32'd0);
        @(negedge clk);
        chk("rst_wbValid", {31'b0, wbValid}, 32'd0);
        chk("rst_aluData", aluData, 32'd0);
        chk("rst_memStall", {31'b0, memStall}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        op(1,1,0,1,1,3'b000,32'h1003,32'h0,5,0,32'h80FF0000,32'hFFFFFF80,1,0,1,0,4'h0,32'h0);
        op(1,0,1,0,0,3'b001,32'h2002,32'h1234ABCD,0,3,32'h0,32'h0,0,0,1,0,4'b1100,32'hABCDABCD);
        op(1,1,0,1,1,3'b010,32'h3001,32'h0,9,0,32'h0,32'h0,0,1,0,0,4'h0,32'h0);
        op(1,0,0,1,0,3'b000,32'h55,32'h0,7,0,32'hDEADBEEF,32'h0,1,0,0,1,4'h0,32'h0);
        op(1,1,0,1,1,3'b101,32'h4002,32'h0,10,1,32'hBEEF1234,32'h0000BEEF,1,0,1,0,4'h0,32'h0);
        op(1,0,1,0,0,3'b010,32'h4004,32'hCAFEF00D,0,1,32'h0,32'h0,0,0,1,0,4'b1111,32'hCAFEF00D);
        op(1,1,0,1,1,3'b001,32'h10,32'h0,11,0,32'h00008001,32'hFFFF8001,1,0,1,0,4'h0,32'h0);
        op(1,1,0,1,1,3'b100,32'h11,32'h0,12,2,32'h0000AB00,32'h000000AB,1,0,1,0,4'h0,32'h0);
        op(1,0,1,0,0,3'b000,32'h22,32'h77,0,0,32'h0,32'h0,0,0,1,0,4'b0100,32'h77777777);
        op(1,1,0,1,1,3'b011,32'h0,32'h0,13,0,32'h0,32'h0,0,1,0,0,4'h0,32'h0);
        op(1,0,1,0,0,3'b100,32'h8,32'h1,0,0,32'h0,32'h0,0,1,0,0,4'h0,32'h0);
        op(0,1,0,1,1,3'b010,32'h100,32'h0,14,0,32'h0,32'h0,0,0,0,0,4'h0,32'h0);
        op(1,1,0,1,1,3'b010,32'h20,32'h0,15,0,32'h12345678,32'h12345678,1,0,1,0,4'h0,32'h0);
        exValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; aluResult = 32'h5000;
        regWriteIn = 1'b1; rdIn = 5'd3; wbSelIn = 1'b1; dmem.dmemReady = 1'b0;
        @(negedge clk);
        chk("pre_rst_stall", {31'b0, memStall}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait_dmemReq", {31'b0, dmem.dmemReq}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dmemReq", {31'b0, dmem.dmemReq}, 32'd0);
        chk("midrst_memStall", {31'b0, memStall}, 32'd0);
        chk("midrst_wbValid", {31'b0, wbValid}, 32'd0);
        chk("midrst_aluData", aluData, 32'd0);
        chk("midrst_regWrite", {31'b0, regWrite}, 32'd0);
        chk("midrst_dmemAddr", dmem.dmemAddr, 32'd0);
        exValid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        op(1,1,0,1,1,3'b010,32'h5000,32'h0,3,0,32'hA5A55A5A,32'hA5A55A5A,1,0,1,0,4'h0,32'h0);
        exValid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end
endmodule
